// File: rtl/prio_branch_arbiter.sv
// Two-requester fixed-priority arbiter (X over Y) with a starvation override for Y
// and saturating per-branch decision counters (X win, Y win, idle with no request).
module prio_branch_arbiter #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_x,
    input  logic             req_y,
    input  logic             done,
    input  logic             clr_cnt,
    output logic             gnt_x,
    output logic             gnt_y,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_x,
    output logic [CNT_W-1:0] cnt_y,
    output logic [CNT_W-1:0] cnt_none,
    output logic             ovr
);

    localparam int unsigned WAIT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_X,
        GRANT_Y
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_y_q, wait_y_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  cnt_x_q, cnt_x_d;
    logic [CNT_W-1:0]  cnt_y_q, cnt_y_d;
    logic [CNT_W-1:0]  cnt_none_q, cnt_none_d;

    logic in_idle;
    logic starve;
    logic win_ovr;
    logic win_x;
    logic win_y;
    logic idle_none;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en,
        input logic             clr
    );
        logic [CNT_W-1:0] r;
        r = v;
        if (clr) begin
            r = '0;
        end else if (en && (v != '1)) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // wait_y saturates at WAIT_MAX, so equality is the same test as >=; with
    // STARVE_LIMIT=0 it never moves off zero and the override stays disabled.
    always_comb begin
        in_idle   = (state_q == IDLE);
        starve    = (STARVE_LIMIT != 0) && (wait_y_q == WAIT_MAX);
        win_ovr   = in_idle && req_y && starve;
        win_y     = in_idle && req_y && (starve || !req_x);
        win_x     = in_idle && req_x && !win_ovr;
        idle_none = in_idle && !req_x && !req_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_y) begin
                    state_d = GRANT_Y;
                end else if (win_x) begin
                    state_d = GRANT_X;
                end
            end
            GRANT_X, GRANT_Y: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_x = (state_q == GRANT_X);
        gnt_y = (state_q == GRANT_Y);
        busy  = gnt_x | gnt_y;
        ovr   = ovr_q;
    end

    always_comb begin
        wait_y_d = wait_y_q;
        if (win_y) begin
            wait_y_d = '0;
        end else if ((state_q == GRANT_X) && req_y && (wait_y_q != WAIT_MAX)) begin
            wait_y_d = wait_y_q + WAIT_W'(1);
        end
        ovr_d      = win_ovr;
        cnt_x_d    = sat_inc(cnt_x_q, win_x, clr_cnt);
        cnt_y_d    = sat_inc(cnt_y_q, win_y, clr_cnt);
        cnt_none_d = sat_inc(cnt_none_q, idle_none, clr_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_y_q   <= '0;
            ovr_q      <= 1'b0;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            cnt_none_q <= '0;
        end else begin
            wait_y_q   <= wait_y_d;
            ovr_q      <= ovr_d;
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            cnt_none_q <= cnt_none_d;
        end
    end

    assign cnt_x    = cnt_x_q;
    assign cnt_y    = cnt_y_q;
    assign cnt_none = cnt_none_q;

    a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_x && gnt_y));
    a_ovr_gnt:  assert property (@(posedge clk) disable iff (!rst_n) ovr |-> gnt_y);

endmodule

// File: tb/tb_prio_branch_arbiter.sv
// Bench for prio_branch_arbiter: three parameterisations share one stimulus stream and
// are checked against a per-instance ownership/tally model plus directed scenarios.
module tb_prio_branch_arbiter;

    localparam int N = 3;
    localparam int LIM  [N] = '{4, 0, 4};
    localparam int CMAX [N] = '{65535, 65535, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_x = 1'b0;
    logic req_y = 1'b0;
    logic done = 1'b0;
    logic clr_cnt = 1'b0;

    logic        gx0, gy0, bz0, ov0, gx1, gy1, bz1, ov1, gx2, gy2, bz2, ov2;
    logic [15:0] cx0, cy0, cn0, cx1, cy1, cn1;
    logic [1:0]  cx2, cy2, cn2;

    logic gx [N];
    logic gy [N];
    logic bz [N];
    logic ov [N];
    int   dcx [N];
    int   dcy [N];
    int   dcn [N];

    int m_own  [N];
    int m_wait [N];
    int m_cx   [N];
    int m_cy   [N];
    int m_cn   [N];
    bit m_ovr  [N];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_branch_arbiter #(.CNT_W(16), .STARVE_LIMIT(4)) u_a (
        .clk(clk), .rst_n(rst_n), .req_x(req_x), .req_y(req_y), .done(done), .clr_cnt(clr_cnt),
        .gnt_x(gx0), .gnt_y(gy0), .busy(bz0), .cnt_x(cx0), .cnt_y(cy0), .cnt_none(cn0), .ovr(ov0));
    prio_branch_arbiter #(.CNT_W(16), .STARVE_LIMIT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_x(req_x), .req_y(req_y), .done(done), .clr_cnt(clr_cnt),
        .gnt_x(gx1), .gnt_y(gy1), .busy(bz1), .cnt_x(cx1), .cnt_y(cy1), .cnt_none(cn1), .ovr(ov1));
    prio_branch_arbiter #(.CNT_W(2), .STARVE_LIMIT(4)) u_c (
        .clk(clk), .rst_n(rst_n), .req_x(req_x), .req_y(req_y), .done(done), .clr_cnt(clr_cnt),
        .gnt_x(gx2), .gnt_y(gy2), .busy(bz2), .cnt_x(cx2), .cnt_y(cy2), .cnt_none(cn2), .ovr(ov2));

    assign gx[0] = gx0;  assign gy[0] = gy0;  assign bz[0] = bz0;  assign ov[0] = ov0;
    assign gx[1] = gx1;  assign gy[1] = gy1;  assign bz[1] = bz1;  assign ov[1] = ov1;
    assign gx[2] = gx2;  assign gy[2] = gy2;  assign bz[2] = bz2;  assign ov[2] = ov2;
    assign dcx[0] = int'(cx0);  assign dcy[0] = int'(cy0);  assign dcn[0] = int'(cn0);
    assign dcx[1] = int'(cx1);  assign dcy[1] = int'(cy1);  assign dcn[1] = int'(cn1);
    assign dcx[2] = int'(cx2);  assign dcy[2] = int'(cy2);  assign dcn[2] = int'(cn2);

    function automatic int bump(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_own[k] = 0; m_wait[k] = 0; m_cx[k] = 0; m_cy[k] = 0; m_cn[k] = 0; m_ovr[k] = 1'b0;
        end
    endtask

    // Owner: 0 = nobody, 1 = X, 2 = Y. Evaluated with the inputs present at the edge.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            if (rst_n) begin
                m_ovr[k] = 1'b0;
                if (m_own[k] == 0) begin
                    if (req_y && LIM[k] != 0 && m_wait[k] >= LIM[k]) begin
                        m_own[k] = 2; m_cy[k] = bump(m_cy[k], CMAX[k]); m_ovr[k] = 1'b1; m_wait[k] = 0;
                    end else if (req_x) begin
                        m_own[k] = 1; m_cx[k] = bump(m_cx[k], CMAX[k]);
                    end else if (req_y) begin
                        m_own[k] = 2; m_cy[k] = bump(m_cy[k], CMAX[k]); m_wait[k] = 0;
                    end else begin
                        m_cn[k] = bump(m_cn[k], CMAX[k]);
                    end
                end else begin
                    if (m_own[k] == 1 && req_y && m_wait[k] < LIM[k]) m_wait[k]++;
                    if (done) m_own[k] = 0;
                end
                if (clr_cnt) begin
                    m_cx[k] = 0; m_cy[k] = 0; m_cn[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_x = 1'b0; req_y = 1'b0; done = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_x = 1'b0; req_y = 1'b0; done = 1'b0; clr_cnt = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if ({gx[k], gy[k], bz[k], ov[k]} !== 4'b0000 || dcx[k] != 0 || dcy[k] != 0 || dcn[k] != 0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: gx=%b gy=%b busy=%b ovr=%b cx=%0d cy=%0d cn=%0d, required all 0",
                         k, gx[k], gy[k], bz[k], ov[k], dcx[k], dcy[k], dcn[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < N; k++) begin
            int exp_cn;
            exp_cn = (5 > CMAX[k]) ? CMAX[k] : 5;
            n_chk++;
            if (gx[k] !== 1'b0 || gy[k] !== 1'b0 || dcx[k] != 0 || dcy[k] != 0 || dcn[k] != exp_cn) begin
                n_fail++;
                $display("FAIL idle_count inst%0d: gx=%b gy=%b cx=%0d cy=%0d cn=%0d, required 0 0 0 0 %0d",
                         k, gx[k], gy[k], dcx[k], dcy[k], dcn[k], exp_cn);
            end
        end
    endtask

    task automatic test_grant_x();
        logic exp_g [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        req_x = 1'b1;
        for (int e = 0; e < 5; e++) begin
            done = (e == 3 || e == 4) ? 1'b1 : 1'b0;
            tick();
            req_x = 1'b0;
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if (gx[k] !== exp_g[e] || bz[k] !== exp_g[e] || gy[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL grant_x_timing inst%0d edge%0d: gx=%b busy=%b gy=%b, required gx=busy=%b gy=0",
                             k, e, gx[k], bz[k], gy[k], exp_g[e]);
                end
            end
        end
        done = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (dcx[k] != 1 || dcn[k] != 1 || dcy[k] != 0) begin
                n_fail++;
                $display("FAIL grant_x_counts inst%0d: cx=%0d cn=%0d cy=%0d, required 1 1 0", k, dcx[k], dcn[k], dcy[k]);
            end
        end
    endtask

    task automatic test_no_override();
        do_reset();
        req_x = 1'b1; req_y = 1'b1;
        for (int e = 0; e < 12; e++) begin
            done = (e % 3 == 2) ? 1'b1 : 1'b0;
            tick();
            n_chk++;
            if (gx[1] !== (e % 3 != 2) || gy[1] !== 1'b0 || ov[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL no_override_seq edge%0d: gx=%b gy=%b ovr=%b, required gx=%b gy=0 ovr=0",
                         e, gx[1], gy[1], ov[1], (e % 3 != 2));
            end
            n_chk++;
            if (gx[0] !== (m_own[0] == 1) || gy[0] !== (m_own[0] == 2) || ov[0] !== m_ovr[0]) begin
                n_fail++;
                $display("FAIL limit4_seq edge%0d: gx=%b gy=%b ovr=%b, required %b %b %b",
                         e, gx[0], gy[0], ov[0], m_own[0] == 1, m_own[0] == 2, m_ovr[0]);
            end
        end
        done = 1'b0; req_x = 1'b0; req_y = 1'b0;
        n_chk++;
        if (dcx[1] != 4 || dcy[1] != 0) begin
            n_fail++;
            $display("FAIL no_override_counts: cx=%0d cy=%0d, required 4 0", dcx[1], dcy[1]);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        req_x = 1'b1; req_y = 1'b1;
        for (int e = 0; e < 6; e++) begin
            done = (e == 5) ? 1'b1 : 1'b0;
            tick();
        end
        done = 1'b0;
        tick();
        for (int k = 0; k < N; k += 2) begin
            n_chk++;
            if (gy[k] !== 1'b1 || gx[k] !== 1'b0 || ov[k] !== 1'b1 || dcy[k] != 1 || dcx[k] != 1) begin
                n_fail++;
                $display("FAIL starve_override inst%0d: gy=%b gx=%b ovr=%b cy=%0d cx=%0d, required 1 0 1 1 1",
                         k, gy[k], gx[k], ov[k], dcy[k], dcx[k]);
            end
        end
        n_chk++;
        if (gx[1] !== 1'b1 || ov[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_disabled: gx=%b ovr=%b, required 1 0", gx[1], ov[1]);
        end
        tick();
        n_chk++;
        if (ov[0] !== 1'b0 || gy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_one_pulse: ovr=%b gy=%b, required 0 1", ov[0], gy[0]);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_chk++;
        if (gx[0] !== 1'b1 || gy[0] !== 1'b0 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_y_cleared: gx=%b gy=%b ovr=%b, required 1 0 0", gx[0], gy[0], ov[0]);
        end
        req_x = 1'b0; req_y = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (4) tick();
        n_chk++;
        if (dcn[2] != 3) begin
            n_fail++;
            $display("FAIL sat_cnt_none: cn=%0d, required 3", dcn[2]);
        end
        repeat (2) tick();
        n_chk++;
        if (dcn[2] != 3 || dcn[0] != 6) begin
            n_fail++;
            $display("FAIL sat_hold: cn2=%0d cn0=%0d, required 3 6", dcn[2], dcn[0]);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_chk++;
        if (dcn[2] != 0 || dcn[0] != 0) begin
            n_fail++;
            $display("FAIL clr_precedence: cn2=%0d cn0=%0d, required 0 0", dcn[2], dcn[0]);
        end
        tick();
        n_chk++;
        if (dcn[2] != 1) begin
            n_fail++;
            $display("FAIL count_after_clr: cn=%0d, required 1", dcn[2]);
        end
    endtask

    task automatic test_one_cycle_grant();
        do_reset();
        req_x = 1'b1; done = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_chk++;
            if (gx[0] !== (e % 2 == 0)) begin
                n_fail++;
                $display("FAIL one_cycle_grant edge%0d: gx=%b, required %b", e, gx[0], (e % 2 == 0));
            end
        end
        req_x = 1'b0; done = 1'b0;
        n_chk++;
        if (dcx[0] != 2) begin
            n_fail++;
            $display("FAIL one_cycle_count: cx=%0d, required 2", dcx[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_x = 1'b1;
        tick();
        req_x = 1'b0;
        tick();
        n_chk++;
        if (gx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_grant: gx=%b, required 1", gx[0]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (gx[0] !== 1'b0 || bz[0] !== 1'b0 || gx[2] !== 1'b0 || bz[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_drop: gx0=%b busy0=%b gx2=%b busy2=%b, required all 0", gx[0], bz[0], gx[2], bz[2]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (dcx[k] != 0 || dcy[k] != 0 || dcn[k] != 0 || gx[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset inst%0d: cx=%0d cy=%0d cn=%0d gx=%b, required 0", k, dcx[k], dcy[k], dcn[k], gx[k]);
            end
        end
        req_x = 1'b1;
        tick();
        req_x = 1'b0;
        n_chk++;
        if (gx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: gx=%b, required 1", gx[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_x   = ($urandom_range(0, 99) < 45);
            req_y   = ($urandom_range(0, 99) < 60);
            done    = ($urandom_range(0, 99) < 25);
            clr_cnt = ($urandom_range(0, 99) < 2);
            tick();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if (gx[k] !== (m_own[k] == 1) || gy[k] !== (m_own[k] == 2) || bz[k] !== (m_own[k] != 0) ||
                    ov[k] !== m_ovr[k] || dcx[k] != m_cx[k] || dcy[k] != m_cy[k] || dcn[k] != m_cn[k]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: gx=%b gy=%b busy=%b ovr=%b cx=%0d cy=%0d cn=%0d, required %b %b %b %b %0d %0d %0d",
                             k, c, gx[k], gy[k], bz[k], ov[k], dcx[k], dcy[k], dcn[k],
                             m_own[k] == 1, m_own[k] == 2, m_own[k] != 0, m_ovr[k], m_cx[k], m_cy[k], m_cn[k]);
                end
            end
        end
        req_x = 1'b0; req_y = 1'b0; done = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_grant_x();
        test_no_override();
        test_starvation();
        test_saturation();
        test_one_cycle_grant();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/prio_branch_arbiter.md
Name: prio_branch_arbiter

Overview:
Two-requester fixed-priority arbiter with an anti-starvation override and per-branch decision counters.
Requester X beats requester Y, and the "neither" case is counted as a branch of its own.
The block sequences access to one shared resource (for example the message/display sink) between two sources.
Its counters give a hardware tally of each arbitration branch taken, for cross-checking branch-coverage results.

Parameters:
CNT_W, 16, width of each saturating branch counter (must be >= 2).
STARVE_LIMIT, 4, number of GRANT_X cycles with req_y pending before Y is forced to win the next arbitration; 0 disables the override.

Ports:
clk  in  1  single clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_x  in  1  request from X (high priority); level, sampled only in IDLE.
req_y  in  1  request from Y (low priority); level.
done  in  1  current grant holder finished; one-cycle pulse, ignored in IDLE.
clr_cnt  in  1  synchronous clear of cnt_x, cnt_y and cnt_none.
gnt_x  out  1  X owns resource (registered).
gnt_y  out  1  Y owns resource (registered).
busy  out  1  gnt_x | gnt_y.
cnt_x  out  CNT_W  arbitrations won by X.
cnt_y  out  CNT_W  arbitrations won by Y, including overrides.
cnt_none  out  CNT_W  IDLE cycles with neither request.
ovr  out  1  one-cycle pulse when Y wins by starvation override.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt_x, gnt_y, busy, ovr, cnt_* and the internal wait_y counter are all 0.
  - Asserting reset mid-grant drops the grant immediately, with no wait for done.
- FSM states: IDLE, GRANT_X, GRANT_Y. gnt_x=(state==GRANT_X), gnt_y=(state==GRANT_Y); gnt_x and gnt_y are never both 1.
- IDLE decision, evaluated every IDLE cycle in this priority order:
  - starve = (STARVE_LIMIT!=0) && wait_y>=STARVE_LIMIT.
  - if req_y && starve -> GRANT_Y, cnt_y++, ovr=1 next cycle.
  - else if req_x -> GRANT_X, cnt_x++.
  - else if req_y -> GRANT_Y, cnt_y++.
  - else stay in IDLE, cnt_none++.
- Latency: request seen in IDLE at edge T -> grant high from T+1.
- GRANT_x/y release: stay in the state until done=1 sampled at edge T.
  - IDLE from T+1, grant low at T+1.
  - Earliest next grant is T+2, so there is always at least one idle cycle between grants.
  - Withdrawing a request during a grant does not release it; only done does.
- wait_y:
  - Increments on each GRANT_X cycle with req_y=1, saturating at STARVE_LIMIT.
  - Holds its value in IDLE.
  - Clears to 0 on entry to GRANT_Y.
  - Stays 0 when STARVE_LIMIT=0.
- Counters:
  - Saturate at all-ones, with no wrap.
  - clr_cnt takes precedence, so an increment in the same cycle is lost and the result is 0.
  - clr_cnt does not affect the FSM or wait_y.
- done in IDLE: ignored, and the counters are unaffected.
- done asserted in the same cycle a grant is first entered: it is sampled in the grant state, so a one-cycle grant is legal.

Test Plan:
1. Release reset, hold req_x=req_y=0 for 5 cycles -> gnt_x=gnt_y=0, cnt_none=5, cnt_x=cnt_y=0.
2. req_x=1 at edge T, done at T+3 -> gnt_x high T+1..T+3, low T+4, cnt_x=1.
3. req_x=req_y=1 held, done every 2nd grant cycle, STARVE_LIMIT=0 -> only gnt_x is ever granted; cnt_x counts grants, cnt_y stays 0.
4. STARVE_LIMIT=4, both requests held, X grant lasts 5 cycles -> next arbitration gives gnt_y despite req_x, ovr pulses once, wait_y returns to 0.
5. CNT_W=2, 4 idle no-request cycles -> cnt_none=3 and stays 3; then clr_cnt in the same cycle as an increment -> cnt_none=0.
6. rst_n low during GRANT_X -> gnt_x and busy fall without a clock edge; after release, state is IDLE and all counters read 0.
